// File: rtl/cordic_pkg.sv
// Shared constants and types for the iterative CORDIC engine.
// The ATAN table holds round(atan(2^-i) * 2^30) for i = 0..31.
package cordic_pkg;

  localparam int FRAC = 30;

  localparam logic [31:0] INV_K = 32'h26DD3B6A;

  localparam logic [31:0] ATAN [32] = '{
    32'h3243F6A9, 32'h1DAC6705, 32'h0FADBAFD, 32'h07F56EA7,
    32'h03FEAB77, 32'h01FFD55C, 32'h00FFFAAB, 32'h007FFF55,
    32'h003FFFEB, 32'h001FFFFD, 32'h00100000, 32'h00080000,
    32'h00040000, 32'h00020000, 32'h00010000, 32'h00008000,
    32'h00004000, 32'h00002000, 32'h00001000, 32'h00000800,
    32'h00000400, 32'h00000200, 32'h00000100, 32'h00000080,
    32'h00000040, 32'h00000020, 32'h00000010, 32'h00000008,
    32'h00000004, 32'h00000002, 32'h00000001, 32'h00000000
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } mode_e;

  // High-ones mask that sign-fills a logical right shift by sh bits.
  function automatic logic [31:0] sra_mask(input logic [4:0] sh);
    return ~(32'hFFFF_FFFF >> sh);
  endfunction

endpackage

// File: rtl/shift.sv
// 32-bit logical barrel shifter: rightleft=0 shifts right, 1 shifts left.
// Zeros are shifted in from either end.
module shift (
  input  logic [31:0] data_in,
  input  logic        rightleft,
  input  logic [4:0]  shift_amount,
  output logic [31:0] data_out
);

  assign data_out = rightleft ? (data_in << shift_amount) : (data_in >> shift_amount);

endmodule

// File: rtl/cordic_iter_core.sv
// Iterative CORDIC: one micro-rotation per clock, rotation or vectoring mode.
// States: IDLE wait for sample | RUN one micro-rotation per clk | DONE hold result until taken
module cordic_iter_core
  import cordic_pkg::*;
#(
  parameter int N_ITER = 24,
  parameter int W      = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic         i_in_mode,
  input  logic [W-1:0] i_in_x,
  input  logic [W-1:0] i_in_y,
  input  logic [W-1:0] i_in_z,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_x,
  output logic [W-1:0] o_out_y,
  output logic [W-1:0] o_out_z
);

  localparam logic [4:0] LAST_I = 5'(N_ITER - 1);

  state_e       r_state;
  mode_e        r_mode;
  logic [4:0]   r_i;
  logic [W-1:0] r_x, r_y, r_z;
  logic         r_in_ready;
  logic         r_out_valid;

  logic [W-1:0] w_x_shr, w_y_shr, w_mask, w_x_sra, w_y_sra;
  logic [W-1:0] w_atan, w_x_nxt, w_y_nxt, w_z_nxt;
  logic         w_d_pos;

  shift u_shift_x (
    .data_in      (r_x),
    .rightleft    (1'b0),
    .shift_amount (r_i),
    .data_out     (w_x_shr)
  );

  shift u_shift_y (
    .data_in      (r_y),
    .rightleft    (1'b0),
    .shift_amount (r_i),
    .data_out     (w_y_shr)
  );

  // Arithmetic shift = logical shift with the vacated high bits refilled by the sign.
  assign w_mask  = sra_mask(r_i);
  assign w_x_sra = w_x_shr | (r_x[W-1] ? w_mask : '0);
  assign w_y_sra = w_y_shr | (r_y[W-1] ? w_mask : '0);
  assign w_atan  = ATAN[r_i];

  assign w_d_pos = (r_mode == MODE_ROT) ? ~r_z[W-1] : r_y[W-1];
  assign w_x_nxt = w_d_pos ? (r_x - w_y_sra) : (r_x + w_y_sra);
  assign w_y_nxt = w_d_pos ? (r_y + w_x_sra) : (r_y - w_x_sra);
  assign w_z_nxt = w_d_pos ? (r_z - w_atan)  : (r_z + w_atan);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mode      <= MODE_ROT;
      r_i         <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready <= 1'b1;
          if (i_in_valid && r_in_ready) begin
            r_x        <= i_in_x;
            r_y        <= i_in_y;
            r_z        <= i_in_z;
            r_mode     <= mode_e'(i_in_mode);
            r_i        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_x <= w_x_nxt;
          r_y <= w_y_nxt;
          r_z <= w_z_nxt;
          r_i <= r_i + 5'd1;
          if (r_i == LAST_I) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_x     = r_x;
  assign o_out_y     = r_y;
  assign o_out_z     = r_z;

endmodule

// File: tb/tb_cordic_iter_core.sv
// Directed bench for cordic_iter_core: reset, rotation/vectoring vectors, handshake timing.
// Numeric tolerance covers the residual angle of the final step (ATAN[23] = 128 LSB) plus shift truncation.
module tb_cordic_iter_core;
  import cordic_pkg::*;

  localparam int N   = 24;
  localparam int TOL = 256;

  localparam logic [31:0] PI4     = 32'h3243F6A9;
  localparam logic [31:0] PI4_NEG = 32'hCDBC0957;
  localparam logic [31:0] SQH     = 32'h2D413CCD;
  localparam logic [31:0] SQH_NEG = 32'hD2BEC333;
  localparam logic [31:0] VEC_MAG = 32'h4A861BD3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic        i_in_mode = 1'b0;
  logic [31:0] i_in_x = '0, i_in_y = '0, i_in_z = '0;
  logic        o_out_valid;
  logic        i_out_ready = 1'b0;
  logic [31:0] o_out_x, o_out_y, o_out_z;

  int cyc = 0;
  int t_acc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] one_q;

  cordic_iter_core #(.N_ITER(N), .W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_mode   (i_in_mode),
    .i_in_x      (i_in_x),
    .i_in_y      (i_in_y),
    .i_in_z      (i_in_z),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_x     (o_out_x),
    .o_out_y     (o_out_y),
    .o_out_z     (o_out_z)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol);
    longint d;
    n_cmp++;
    d = longint'($signed(obs - exp));
    if (d < 0) d = -d;
    if (d > longint'(tol)) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic send(input logic mode, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    int n = 0;
    @(negedge clk);
    i_in_valid = 1'b1;
    i_in_mode  = mode;
    i_in_x     = x;
    i_in_y     = y;
    i_in_z     = z;
    while (!o_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("acc_rdy", 32'(o_in_ready), 32'd1, 0);
    @(posedge clk);
    #1;
    t_acc = cyc;
    // Garbage after the accept edge must not disturb the running sample.
    i_in_valid = 1'b0;
    i_in_mode  = ~mode;
    i_in_x     = 32'h7FFF_FFFF;
    i_in_y     = 32'h8000_0001;
    i_in_z     = 32'h5A5A_5A5A;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!o_out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 32'(cyc - t_acc), 32'(N), 0);
  endtask

  task automatic drain();
    @(negedge clk);
    i_out_ready = 1'b1;
    @(posedge clk);
    #1;
    i_out_ready = 1'b0;
    check("drain_ovalid", 32'(o_out_valid), 32'd0, 0);
    check("drain_irdy", 32'(o_in_ready), 32'd1, 0);
  endtask

  initial begin
    int t0, t1, t2, nacc, n;
    one_q = 32'd1 << FRAC;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_ovalid", 32'(o_out_valid), 32'd0, 0);
    check("rst_irdy", 32'(o_in_ready), 32'd0, 0);
    check("rst_ox", o_out_x, 32'd0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_irdy", 32'(o_in_ready), 32'd1, 0);

    // Rotation, zero angle
    send(MODE_ROT, INV_K, 32'd0, 32'd0);
    wait_done("lat_rot0");
    check("rot0_x", o_out_x, one_q, TOL);
    check("rot0_y", o_out_y, 32'd0, TOL);
    check("rot0_z", o_out_z, 32'd0, TOL);
    drain();

    // Rotation, +pi/4
    send(MODE_ROT, INV_K, 32'd0, PI4);
    wait_done("lat_rotp");
    check("rotp_x", o_out_x, SQH, TOL);
    check("rotp_y", o_out_y, SQH, TOL);
    drain();

    // Rotation, -pi/4 (negative sign-fill path)
    send(MODE_ROT, INV_K, 32'd0, PI4_NEG);
    wait_done("lat_rotn");
    check("rotn_x", o_out_x, SQH, TOL);
    check("rotn_y", o_out_y, SQH_NEG, TOL);
    check("rotn_z", o_out_z, 32'd0, TOL);
    drain();

    // Vectoring
    send(MODE_VEC, 32'h2000_0000, 32'h2000_0000, 32'd0);
    wait_done("lat_vec");
    check("vec_x", o_out_x, VEC_MAG, TOL);
    check("vec_y", o_out_y, 32'd0, TOL);
    check("vec_z", o_out_z, PI4, TOL);
    drain();

    // Hold out_ready low in DONE while a new sample is offered
    send(MODE_ROT, INV_K, 32'd0, PI4);
    wait_done("lat_hold");
    @(negedge clk);
    i_in_valid = 1'b1;
    i_in_mode  = MODE_VEC;
    i_in_x     = 32'h2000_0000;
    i_in_y     = 32'h2000_0000;
    i_in_z     = 32'd0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check("hold_ovalid", 32'(o_out_valid), 32'd1, 0);
      check("hold_irdy", 32'(o_in_ready), 32'd0, 0);
      check("hold_x", o_out_x, SQH, TOL);
      check("hold_y", o_out_y, SQH, TOL);
    end
    @(negedge clk) i_out_ready = 1'b1;
    @(posedge clk);
    #1;
    i_out_ready = 1'b0;
    check("hs_ovalid", 32'(o_out_valid), 32'd0, 0);
    check("hs_irdy", 32'(o_in_ready), 32'd1, 0);
    @(posedge clk);
    #1;
    t_acc = cyc;
    check("hs_next_acc", 32'(o_in_ready), 32'd0, 0);
    i_in_valid = 1'b0;
    i_in_x     = 32'h7FFF_FFFF;
    wait_done("lat_hs");
    check("hs_vec_x", o_out_x, VEC_MAG, TOL);
    check("hs_vec_z", o_out_z, PI4, TOL);
    drain();

    // Back-to-back with out_ready held high
    @(negedge clk);
    i_in_valid  = 1'b1;
    i_in_mode   = MODE_ROT;
    i_in_x      = INV_K;
    i_in_y      = 32'd0;
    i_in_z      = 32'd0;
    i_out_ready = 1'b1;
    t0 = -1000; t1 = -2000; t2 = -3000;
    nacc = 0;
    n = 0;
    while (nacc < 3 && n < 400) begin
      if (o_in_ready) begin
        if (nacc == 0) t0 = cyc + 1;
        else if (nacc == 1) t1 = cyc + 1;
        else t2 = cyc + 1;
        nacc++;
      end
      @(negedge clk);
      n++;
    end
    i_in_valid = 1'b0;
    check("b2b_gap1", 32'(t1 - t0), 32'(N + 2), 0);
    check("b2b_gap2", 32'(t2 - t1), 32'(N + 2), 0);
    n = 0;
    while (!o_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    i_out_ready = 1'b0;
    check("b2b_idle", 32'(o_in_ready), 32'd1, 0);

    // Reset mid-RUN
    send(MODE_ROT, INV_K, 32'd0, PI4);
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("mrun_ovalid", 32'(o_out_valid), 32'd0, 0);
    check("mrun_ox", o_out_x, 32'd0, 0);
    check("mrun_oy", o_out_y, 32'd0, 0);
    check("mrun_irdy", 32'(o_in_ready), 32'd0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mrun_rel_irdy", 32'(o_in_ready), 32'd1, 0);

    // Reset mid-DONE
    send(MODE_VEC, 32'h2000_0000, 32'h2000_0000, 32'd0);
    wait_done("lat_mdone");
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("mdone_ovalid", 32'(o_out_valid), 32'd0, 0);
    check("mdone_ox", o_out_x, 32'd0, 0);
    check("mdone_oz", o_out_z, 32'd0, 0);
    @(negedge clk) rst_n = 1'b1;

    // Core works normally after reset
    send(MODE_ROT, INV_K, 32'd0, PI4_NEG);
    wait_done("lat_post");
    check("post_y", o_out_y, SQH_NEG, TOL);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
